// File: rtl/interp_upsample_feed.sv
// Zero-stuffing upsampler feeding the interpolation FIR: buffers low-rate samples in a small
// FIFO and emits each one followed by UPSAMPLE_FACTOR-1 zero words, one word per enabled clock.
module interp_upsample_feed #(
    parameter  int DATA_WIDTH      = 5,
    parameter  int UPSAMPLE_FACTOR = 4,
    parameter  int FIFO_DEPTH      = 4,
    localparam int PH_W            = (UPSAMPLE_FACTOR > 1) ? $clog2(UPSAMPLE_FACTOR) : 1,
    localparam int PTR_W           = $clog2(FIFO_DEPTH),
    localparam int LVL_W           = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out,
    output logic        [PH_W-1:0]       phase,
    output logic        [LVL_W-1:0]      fifo_level,
    output logic                         underrun,
    input  logic                         clr_underrun
);

    logic signed [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic        [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic        [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic        [LVL_W-1:0]      level_q, level_d;
    logic        [PH_W-1:0]       phase_q, phase_d;
    logic signed [DATA_WIDTH-1:0] out_q, out_d;
    logic                         underrun_q, underrun_d;

    logic push, pop, slot, empty;

    // in_ready looks only at the stored count, so a same-edge pop never opens a full FIFO.
    assign in_ready = (level_q < LVL_W'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    assign slot     = enable && (phase_q == '0);
    assign push     = in_valid && in_ready;
    assign pop      = slot && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        phase_d    = '0;
        out_d      = '0;
        underrun_d = underrun_q;
        if (clr_underrun) begin
            underrun_d = 1'b0;
        end
        if (enable) begin
            if (phase_q == PH_W'(UPSAMPLE_FACTOR - 1)) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end
        if (pop) begin
            out_d = mem_q[rd_ptr_q];
        end
        // An empty sample slot outranks a same-edge clear so the shortfall is never lost.
        if (slot && empty) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            phase_q    <= '0;
            out_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            phase_q    <= phase_d;
            out_q      <= out_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage is data-only; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out        = out_q;
    assign phase      = phase_q;
    assign fifo_level = level_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_interp_upsample_feed.sv
// Directed bench for interp_upsample_feed: an L=4 instance for the main sequence and an L=1
// instance for full-rate pass-through of the signed extremes.
module tb_interp_upsample_feed;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable, in_valid, clr_underrun;
    logic signed [4:0] in_data;
    logic              in_ready, underrun;
    logic signed [4:0] out;
    logic        [1:0] phase;
    logic        [2:0] fifo_level;

    logic              en1, vld1, clr1, rdy1, und1;
    logic signed [4:0] din1, out1;
    logic        [0:0] ph1;
    logic        [2:0] lvl1;

    int nassert = 0;
    int nfail   = 0;

    always #5 clk = ~clk;

    interp_upsample_feed #(.DATA_WIDTH(5), .UPSAMPLE_FACTOR(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .phase(phase), .fifo_level(fifo_level),
        .underrun(underrun), .clr_underrun(clr_underrun)
    );

    interp_upsample_feed #(.DATA_WIDTH(5), .UPSAMPLE_FACTOR(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .in_data(din1), .in_valid(vld1),
        .in_ready(rdy1), .out(out1), .phase(ph1), .fifo_level(lvl1),
        .underrun(und1), .clr_underrun(clr1)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seq1 [12] = '{7, 0, 0, 0, 3, 0, 0, 0, -5, 0, 0, 0};
        int seq2 [15] = '{0, 0, 0, 2, 0, 0, 0, 3, 0, 0, 0, 4, 0, 0, 0};

        rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0; clr_underrun = 1'b0;
        en1 = 1'b0; vld1 = 1'b0; din1 = '0; clr1 = 1'b0;
        #2;
        chk("rst_out", out, 0);
        chk("rst_phase", phase, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_underrun", underrun, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1);

        // Preload 7, 3, -5 while idle, then run: each sample followed by three zeros.
        in_valid = 1'b1;
        in_data = 5'sd7;  step();
        in_data = 5'sd3;  step();
        in_data = -5'sd5; step();
        in_valid = 1'b0;
        chk("preload_level", fifo_level, 3);
        enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("seq1_out[%0d]", k), out, seq1[k]);
            chk($sformatf("seq1_phase[%0d]", k), phase, (k + 1) % 4);
            chk($sformatf("seq1_underrun[%0d]", k), underrun, 0);
        end
        enable = 1'b0;
        step();
        chk("idle_phase", phase, 0);
        chk("idle_underrun", underrun, 0);

        // Fill while disabled; fifth sample must be refused.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 5'(i + 1);
            chk($sformatf("fill_ready[%0d]", i), in_ready, 1);
            step();
            chk($sformatf("fill_level[%0d]", i), fifo_level, i + 1);
        end
        chk("full_ready", in_ready, 0);
        in_data = 5'sd5;
        step();
        chk("full_level", fifo_level, 4);
        chk("full_ready2", in_ready, 0);

        // Enable while full: pop edge does not accept in_data=9.
        in_data = 5'sd9;
        enable = 1'b1;
        chk("pop_edge_ready", in_ready, 0);
        step();
        in_valid = 1'b0;
        chk("pop_out", out, 1);
        chk("pop_level", fifo_level, 3);
        chk("pop_ready", in_ready, 1);
        chk("pop_phase", phase, 1);
        for (int k = 0; k < 15; k++) begin
            step();
            chk($sformatf("drain_out[%0d]", k), out, seq2[k]);
        end
        chk("drain_level", fifo_level, 0);
        chk("drain_phase", phase, 0);
        chk("drain_underrun", underrun, 0);

        // Underrun on empty slot, clear on phase 1, set beats clear on phase 0.
        step();
        chk("ur_out", out, 0);
        chk("ur_flag", underrun, 1);
        chk("ur_phase", phase, 1);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        chk("ur_clr_ph1", underrun, 0);
        chk("ur_clr_phase", phase, 2);
        step();
        step();
        chk("ur_phase0", phase, 0);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        chk("ur_set_wins", underrun, 1);
        enable = 1'b0;
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        chk("ur_clr_idle", underrun, 0);
        chk("ur_idle_phase", phase, 0);

        // L=1: stream the signed extremes at full rate with overlapping push and pop.
        vld1 = 1'b1; din1 = 5'sd1;
        step();
        chk("l1_level0", lvl1, 1);
        en1 = 1'b1; din1 = -5'sd1;
        step();
        chk("l1_out0", out1, 1);
        chk("l1_level1", lvl1, 1);
        chk("l1_phase", ph1, 0);
        din1 = 5'sd15;
        step();
        chk("l1_out1", out1, -1);
        din1 = -5'sd16;
        step();
        chk("l1_out2", out1, 15);
        vld1 = 1'b0;
        step();
        chk("l1_out3", out1, -16);
        chk("l1_level_end", lvl1, 0);
        chk("l1_underrun", und1, 0);
        en1 = 1'b0;

        // Mid-stream async reset at phase 2 with three entries stored.
        in_valid = 1'b1;
        in_data = 5'sd6;  step();
        in_data = -5'sd7; step();
        in_data = 5'sd8;  step();
        in_data = 5'sd9;  step();
        in_valid = 1'b0;
        enable = 1'b1;
        step();
        chk("mid_out6", out, 6);
        step();
        chk("mid_phase", phase, 2);
        chk("mid_level", fifo_level, 3);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("mid_rst_out", out, 0);
        chk("mid_rst_phase", phase, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_underrun", underrun, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 5'sd11;
        step();
        in_valid = 1'b0;
        chk("post_level", fifo_level, 1);
        enable = 1'b1;
        step();
        chk("post_out", out, 11);
        chk("post_phase", phase, 1);
        chk("post_underrun", underrun, 0);
        enable = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule

// File: doc/interp_upsample_feed.md
Name: interp_upsample_feed

Overview:
- Zero-stuffing upsampler that sits directly upstream of the transposed-form FIR pipeline in the interpolation chain.
- Accepts low-rate signed samples over a valid/ready handshake and buffers them in a small FIFO.
- Emits one output word every enabled clock: each buffered sample followed by UPSAMPLE_FACTOR-1 zeros.
- The FIR consumes the output every clock with no handshake. FIFO shortfall is flagged, never stalled.

Parameters:
- DATA_WIDTH, 5, signed sample width; matches the FIR data width.
- UPSAMPLE_FACTOR, 4, interpolation ratio L; legal range 1..64.
- FIFO_DEPTH, 4, input buffer entries; power of 2, at least 2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  run control; low forces output to zero and holds the phase counter at 0.
- in_data  input  DATA_WIDTH  signed input sample.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  FIFO can accept a sample this cycle.
- out  output  DATA_WIDTH  signed upsampled stream to the FIR input.
- phase  output  $clog2(UPSAMPLE_FACTOR) (min 1)  current phase counter value.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of stored entries.
- underrun  output  1  sticky flag: a sample slot occurred while the FIFO was empty.
- clr_underrun  input  1  synchronous clear for underrun.

Behaviour:
- Reset (rst_n low, async): out=0, phase=0, fifo_level=0, underrun=0, FIFO pointers=0. in_ready=1 combinationally once out of reset.
- in_ready is combinational: (fifo_level < FIFO_DEPTH).
  - Push occurs on an edge where in_valid && in_ready.
  - No bypass: a sample pushed at edge t is not visible for pop until edge t+1.
  - in_ready is independent of enable.
  - When full, in_ready=0 even if a pop happens on the same edge.
- Phase counter, enable=1: phase advances each edge, 0 -> 1 -> ... -> L-1 -> 0 (wrap). With L=1 it stays 0.
- Phase counter, enable=0: phase is set to 0 and out is set to 0 on the next edge; no pop occurs.
- Output register; all cases below are evaluated on an edge with enable=1, using pre-edge phase and fifo_level:
  - phase==0, fifo_level>0: out <= FIFO head; pop.
  - phase==0, fifo_level==0: out <= 0; underrun <= 1; phase still advances.
  - phase!=0: out <= 0.
- Simultaneous push and pop: fifo_level unchanged; both pointers advance modulo FIFO_DEPTH.
- Latency: a sample pushed at edge t appears on out no earlier than edge t+1, i.e. the first phase-0 edge after t.
- clr_underrun=1 at an edge clears underrun. If an underrun event occurs on the same edge, the set wins and underrun=1.
- No arithmetic on data: samples pass bit-exact. Zeros are all-zero words. Gain compensation (xL) lives downstream in the FIR coefficients.
- Asserting reset mid-stream discards FIFO contents and restarts at phase 0; no partial output is held.

Test Plan:
- Reset, enable=1, L=4: push 7, 3, -5 on consecutive cycles -> out = 7,0,0,0,3,0,0,0,-5,0,0,0; phase cycles 0..3; underrun stays 0 while the FIFO is fed ahead.
- Fill check, enable=0, DEPTH=4: push 5 samples back-to-back -> in_ready drops after the 4th push; fifo_level=4; 5th sample not accepted.
- Full plus enable: raise enable while full -> in_ready stays 0 on the pop edge and returns to 1 the following cycle; fifo_level goes 4 -> 3.
- Underrun: enable=1 with the FIFO empty -> out=0 and underrun=1 after the first phase-0 edge.
  - Assert clr_underrun on a phase-1 edge -> underrun=0.
  - Assert clr_underrun on a phase-0 empty edge -> underrun remains 1.
- L=1, DEPTH=4: stream 1, -1, 15, -16 (DATA_WIDTH=5 extremes) -> out passes each sample every cycle, bit-exact, in order.
- Mid-stream reset: rst_n low for 1 cycle while phase=2 and fifo_level=3 -> out=0, phase=0, fifo_level=0, underrun=0 immediately (async); the next pushed sample is emitted at the next phase-0 edge.
